dm_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 16-bit, 64-word data memory `dm`. It shares the single `dm` access port between the CPU memory stage (`cpu_*`) and a debug/loader port (`dbg_*`). It performs at most one access per cycle and registers read data back to the winning requester. The CPU has priority, the debug port is protected from starvation, and the debug port can lock the memory for bursts.

---
 rtl/dm_arbiter.sv | 139 +++++++++++++
 tb/tb_dm_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port arbiter for the single-port data memory. The CPU has priority, a starvation
// counter eventually hands one contested cycle to the debug port, and the debug port can
// lock the memory for bursts. Read data is registered back to the winning requester.
module dm_arbiter #(
  parameter int unsigned AW         = 8,
  parameter int unsigned DW         = 16,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  input  logic          dbg_lock,
  output logic          err,
  output logic          dwe,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata
);

  typedef enum logic [1:0] {StCpuPri, StDbgForce, StDbgLock} state_e;

  localparam logic [3:0]  StarveMax = 4'(STARVE_MAX);
  localparam logic [AW:0] DepthLim  = (AW + 1)'(DEPTH);

  state_e          state_q, state_d;
  logic [3:0]      starve_q, starve_d;
  logic            cpu_rvalid_q, dbg_rvalid_q, err_q;
  logic [DW-1:0]   cpu_rdata_q, dbg_rdata_q;

  logic            lock_exit, cpu_first;
  logic            any_gnt, sel_we, oor;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  // A lock ends on the cycle lock or request drops; that cycle already uses CPU priority.
  assign lock_exit = (state_q == StDbgLock) & (~dbg_lock | ~dbg_req);
  assign cpu_first = (state_q == StCpuPri) | lock_exit;

  // State register and starvation counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StCpuPri;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Next-state and starvation counter update
  always_comb begin
    starve_d = 4'd0;
    if (cpu_gnt && dbg_req) begin
      starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
    end
    state_d = state_q;
    if (dbg_gnt && dbg_lock) begin
      state_d = StDbgLock;
    end else if (cpu_first) begin
      state_d = (starve_d == StarveMax) ? StDbgForce : StCpuPri;
    end else if (state_q == StDbgForce) begin
      if (dbg_gnt || !dbg_req) state_d = StCpuPri;
    end
  end

  // Grant decode; nothing is granted while reset is held
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (reset) begin
      if (cpu_first) begin
        cpu_gnt = cpu_req;
        dbg_gnt = ~cpu_req & dbg_req;
      end else begin
        dbg_gnt = dbg_req;
        cpu_gnt = ~dbg_req & cpu_req;
      end
    end
  end

  // Memory port mux; out-of-range accesses are turned into harmless reads of word 0
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (cpu_gnt) begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      sel_we    = dbg_we;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
    end
    any_gnt = cpu_gnt | dbg_gnt;
    oor     = any_gnt & ({1'b0, sel_addr} >= DepthLim);
    dwe     = any_gnt & sel_we & ~oor;
    addr    = (any_gnt && !oor) ? sel_addr : '0;
    wdata   = any_gnt ? sel_wdata : '0;
  end

  // Read-data capture, valid pulses and error pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      err_q        <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      dbg_rvalid_q <= dbg_gnt & ~dbg_we;
      err_q        <= oor;
      if (cpu_gnt && !cpu_we) cpu_rdata_q <= oor ? '0 : rdata;
      if (dbg_gnt && !dbg_we) dbg_rdata_q <= oor ? '0 : rdata;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small behavioural model of the 64-word memory.
// Inputs change on the falling edge; combinational outputs are checked 1 ns later and
// registered outputs at the following falling edge.
module tb_dm_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_lock;
  logic [7:0]  dbg_addr;
  logic [15:0] dbg_wdata, dbg_rdata;
  logic        err, dwe;
  logic [7:0]  addr;
  logic [15:0] wdata, rdata;

  logic [15:0] mem [64];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clock = ~clock;

  dm_arbiter #(.AW(8), .DW(16), .DEPTH(64), .STARVE_MAX(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .dbg_lock   (dbg_lock),
    .err        (err),
    .dwe        (dwe),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata)
  );

  // Memory model: combinational read, write on the rising edge
  assign rdata = mem[addr[5:0]];
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0;
    end else if (dwe) begin
      mem[addr[5:0]] <= wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic prev_dbg;
    logic exp_dbg;

    // Reset with both ports requesting
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd0; cpu_wdata = 16'h0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'd0; dbg_wdata = 16'h0; dbg_lock = 1'b0;
    repeat (3) next_cycle();
    settle();
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_dbg_gnt", dbg_gnt, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_dbg_rvalid", dbg_rvalid, 0);
    check("rst_err", err, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    check("rst_dwe", dwe, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);

    reset = 1'b1;
    settle();
    check("rel_cpu_gnt", cpu_gnt, 1);
    check("rel_dbg_gnt", dbg_gnt, 0);
    next_cycle();
    cpu_req = 1'b0; dbg_req = 1'b0;
    check("rel_cpu_rvalid", cpu_rvalid, 1);
    next_cycle();

    // CPU write 0x1234 to word 5, then read it back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd5; cpu_wdata = 16'h1234;
    settle();
    check("wr_cpu_gnt", cpu_gnt, 1);
    check("wr_dwe", dwe, 1);
    check("wr_addr", addr, 5);
    check("wr_wdata", wdata, 16'h1234);
    next_cycle();
    cpu_we = 1'b0;
    check("wr_no_rvalid", cpu_rvalid, 0);
    settle();
    check("rd_dwe", dwe, 0);
    check("rd_addr", addr, 5);
    next_cycle();
    cpu_req = 1'b0;
    check("rd_cpu_rvalid", cpu_rvalid, 1);
    check("rd_cpu_rdata", cpu_rdata, 16'h1234);
    next_cycle();
    check("rd_rvalid_pulse", cpu_rvalid, 0);
    check("rd_rdata_hold", cpu_rdata, 16'h1234);

    // Debug writes 0xBEEF to word 7 uncontested
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'd7; dbg_wdata = 16'hBEEF;
    settle();
    check("dwr_dbg_gnt", dbg_gnt, 1);
    next_cycle();

    // Starvation guard: both read continuously; pattern C C C C D repeating
    dbg_we = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd5;
    prev_dbg = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("stv_rvalid_%0d", i), dbg_rvalid, prev_dbg);
      if (prev_dbg) check($sformatf("stv_rdata_%0d", i), dbg_rdata, 16'hBEEF);
      settle();
      exp_dbg = (i % 5 == 4);
      check($sformatf("stv_cpu_gnt_%0d", i), cpu_gnt, !exp_dbg);
      check($sformatf("stv_dbg_gnt_%0d", i), dbg_gnt, exp_dbg);
      prev_dbg = exp_dbg;
      next_cycle();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    check("stv_rvalid_last", dbg_rvalid, 1);
    next_cycle();

    // Debug lock burst: 6 writes, CPU requesting from the second one on
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dbg_addr = 8'(10 + i); dbg_wdata = 16'(16'hA000 + i);
      if (i > 0) cpu_req = 1'b1;
      settle();
      check($sformatf("lck_dbg_gnt_%0d", i), dbg_gnt, 1);
      check($sformatf("lck_cpu_gnt_%0d", i), cpu_gnt, 0);
      check($sformatf("lck_addr_%0d", i), addr, 10 + i);
      next_cycle();
    end
    dbg_lock = 1'b0;
    settle();
    check("unlk_cpu_gnt", cpu_gnt, 1);
    check("unlk_dbg_gnt", dbg_gnt, 0);
    next_cycle();
    cpu_req = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    next_cycle();

    // Out-of-range: write to 64, then read 0xFF
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'd64; dbg_wdata = 16'hDEAD;
    settle();
    check("oor_wr_gnt", dbg_gnt, 1);
    check("oor_wr_dwe", dwe, 0);
    check("oor_wr_addr", addr, 0);
    next_cycle();
    dbg_we = 1'b0; dbg_addr = 8'hFF;
    check("oor_wr_err", err, 1);
    settle();
    check("oor_rd_gnt", dbg_gnt, 1);
    check("oor_rd_dwe", dwe, 0);
    check("oor_rd_addr", addr, 0);
    next_cycle();
    dbg_req = 1'b0;
    check("oor_rd_err", err, 1);
    check("oor_rd_rvalid", dbg_rvalid, 1);
    check("oor_rd_rdata", dbg_rdata, 0);
    next_cycle();
    check("oor_err_pulse", err, 0);
    check("oor_mem0_intact", mem[0], 0);

    // Reset in the middle of a locked read burst
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_lock = 1'b1; dbg_addr = 8'd7;
    settle();
    check("rml_first_gnt", dbg_gnt, 1);
    next_cycle();
    cpu_req = 1'b1;
    settle();
    check("rml_locked_gnt", dbg_gnt, 1);
    next_cycle();
    reset = 1'b0;
    settle();
    check("rml_rst_rvalid", dbg_rvalid, 0);
    check("rml_rst_dbg_gnt", dbg_gnt, 0);
    check("rml_rst_cpu_gnt", cpu_gnt, 0);
    next_cycle();
    check("rml_rst_rvalid2", dbg_rvalid, 0);
    reset = 1'b1;
    settle();
    check("rml_rel_cpu_gnt", cpu_gnt, 1);
    check("rml_rel_dbg_gnt", dbg_gnt, 0);
    next_cycle();
    cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
    check("rml_rel_dbg_rvalid", dbg_rvalid, 0);
    check("rml_rel_cpu_rvalid", cpu_rvalid, 1);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
